// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window on the core bus
// feeding a small TX FIFO that drains into a serializer.
module uart_tx_mmio #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [15:0]           BAUD_DIV_RST = 16'd434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] RWAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Sel,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [15:0]      baud_div;
    logic [15:0]      period;
    logic [15:0]      baud_cnt;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;

    logic [1:0]       offset;
    logic             bus_wr;
    logic             full;
    logic             empty;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic [7:0]       status;
    logic             unused_bits;

    assign Sel      = (RWAddress[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign offset   = RWAddress[3:2];
    assign bus_wr   = Sel & MemWrite;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = bus_wr && (offset == 2'd0);
    assign push     = push_req && !full;
    assign pop      = (state == IDLE) && !empty;
    assign bit_end  = (baud_cnt == period - 16'd1);
    assign status   = {4'(count), ovf, empty, full, state != IDLE};

    assign unused_bits = ^{WriteData[DATA_WIDTH-1:16], RWAddress[1:0]};

    always_comb begin
        RdData = '0;
        if (Sel && MemRead) begin
            case (offset)
                2'd1:    RdData = DATA_WIDTH'(status);
                2'd2:    RdData = DATA_WIDTH'(baud_div);
                default: RdData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // Full is judged before the edge, so a push into a full FIFO is dropped
    // even when the serializer pops in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            baud_div <= BAUD_DIV_RST;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (push_req && full) begin
                ovf <= 1'b1;
            end else if (bus_wr && (offset == 2'd1) && WriteData[3]) begin
                ovf <= 1'b0;
            end
            if (bus_wr && (offset == 2'd2)) begin
                baud_div <= (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
            end
        end
    end

    // The divisor is captured into period at pop time so mid-frame writes only
    // take effect on the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            period   <= BAUD_DIV_RST;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift    <= fifo_mem[rd_ptr];
                        period   <= baud_div;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed bus sequences plus a line monitor that decodes
// frames from tx using the divisor the bench believes is in effect.
module tb_uart_tx_mmio;
    localparam logic [31:0] TXDATA_A  = 32'h1001_0000;
    localparam logic [31:0] STATUS_A  = 32'h1001_0004;
    localparam logic [31:0] BAUDDIV_A = 32'h1001_0008;
    localparam logic [31:0] RSVD_A    = 32'h1001_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] RWAddress = '0;
    logic [31:0] WriteData = '0;
    logic        Sel;
    logic [31:0] RdData;
    logic        tx;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int unsigned model_div = 434;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          start_q[$];

    logic [31:0] rd;
    logic        rd_sel;
    logic [7:0]  frame_byte;
    logic [7:0]  stream_bytes [12];
    int unsigned sdiv;
    int          max_count;
    int          waited;
    bit          pushed;
    logic        exp_bit;

    uart_tx_mmio dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead),
        .RWAddress(RWAddress), .WriteData(WriteData), .Sel(Sel), .RdData(RdData), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        RWAddress = addr;
        WriteData = data;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        if (addr[31:4] == BAUDDIV_A[31:4] && addr[3:2] == 2'd2)
            model_div = (data[15:0] == 16'd0) ? 1 : int'(data[15:0]);
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic s);
        @(negedge clk);
        RWAddress = addr;
        MemWrite  = 1'b0;
        MemRead   = 1'b1;
        #1;
        data = RdData;
        s    = Sel;
        MemRead = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int w = 0;
        while (rx_q.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        checkOutput("rx_frame_count", rx_q.size(), n);
    endtask

    task automatic compare_rx();
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("rx_byte[%0d]", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
    endtask

    // Line monitor: every bit must hold its level for a whole divisor period.
    initial begin : monitor
        logic [9:0] bits;
        int unsigned d;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                d = model_div;
                start_q.push_back(cyc);
                aborted = 0;
                bits = '0;
                for (int k = 0; k < 10 * int'(d) && !aborted; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst !== 1'b1) aborted = 1;
                    else if (k % int'(d) == 0) bits[k / int'(d)] = tx;
                    else checkOutput("bit_stable", tx, bits[k / int'(d)]);
                end
                if (!aborted) begin
                    checkOutput("stop_bit", bits[9], 1'b1);
                    rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state, both during and after reset.
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1'b1);
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("reset_status", rd, 32'h4);
        checkOutput("reset_sel", rd_sel, 1'b1);
        bus_read(BAUDDIV_A, rd, rd_sel);
        checkOutput("reset_bauddiv", rd, 32'd434);
        @(negedge clk) rst = 1'b1;
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("post_reset_status", rd, 32'h4);

        // Address decode and register map corners.
        bus_read(32'h1001_0010, rd, rd_sel);
        checkOutput("decode_hi_sel", rd_sel, 1'b0);
        checkOutput("decode_hi_data", rd, 32'h0);
        bus_read(32'h1000_0004, rd, rd_sel);
        checkOutput("decode_lo_sel", rd_sel, 1'b0);
        checkOutput("decode_lo_data", rd, 32'h0);
        applyStimulus(32'h1001_0018, 32'h5);
        applyStimulus(32'h1000_0000, 32'h55);
        applyStimulus(RSVD_A, 32'hFFFF_FFFF);
        bus_read(BAUDDIV_A, rd, rd_sel);
        checkOutput("decode_bauddiv_kept", rd, 32'd434);
        repeat (5) @(negedge clk);
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("decode_status_kept", rd, 32'h4);
        checkOutput("decode_no_frame", rx_q.size() + start_q.size(), 0);
        bus_read(TXDATA_A, rd, rd_sel);
        checkOutput("txdata_reads_zero", rd, 32'h0);
        bus_read(RSVD_A, rd, rd_sel);
        checkOutput("rsvd_reads_zero", rd, 32'h0);
        applyStimulus(BAUDDIV_A, 32'h0);
        bus_read(BAUDDIV_A, rd, rd_sel);
        checkOutput("bauddiv_zero_is_one", rd, 32'h1);
        applyStimulus(32'h1001_000A, 32'h0001_2345);
        bus_read(BAUDDIV_A, rd, rd_sel);
        checkOutput("bauddiv_low16", rd, 32'h2345);

        // Single frame, cycle-exact.
        applyStimulus(BAUDDIV_A, 32'd4);
        applyStimulus(TXDATA_A, 32'h0000_00A5);
        frame_byte = 8'hA5;
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("pre_pop_status", rd, 32'h10);
        checkOutput("pre_pop_tx", tx, 1'b1);
        for (int k = 0; k < 40; k++) begin
            bus_read(STATUS_A, rd, rd_sel);
            exp_bit = (k < 4) ? 1'b0 : (k < 36) ? frame_byte[(k - 4) / 4] : 1'b1;
            checkOutput($sformatf("frame_tx[%0d]", k), tx, exp_bit);
            checkOutput($sformatf("frame_busy[%0d]", k), rd[0], 1'b1);
        end
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("post_frame_status", rd, 32'h4);
        checkOutput("post_frame_tx", tx, 1'b1);
        exp_q = '{8'hA5};
        compare_rx();
        rx_q.delete();

        // Overflow: one byte in flight, four buffered, the sixth dropped.
        applyStimulus(BAUDDIV_A, 32'd4);
        for (int i = 0; i < 6; i++) applyStimulus(TXDATA_A, 32'h11 + i);
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("ovf_status", rd, 32'h4B);
        applyStimulus(STATUS_A, 32'h8);
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("ovf_cleared_status", rd, 32'h43);
        wait_rx(5, 5 * 41 + 50);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        compare_rx();
        repeat (2) @(negedge clk);
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("ovf_drained_status", rd, 32'h4);
        rx_q.delete();
        start_q.delete();

        // Streaming with wrap-around: later bytes pushed in the cycle of a pop.
        sdiv = $urandom_range(1, 3);
        for (int i = 0; i < 12; i++) stream_bytes[i] = 8'($urandom);
        applyStimulus(BAUDDIV_A, sdiv);
        for (int i = 0; i < 4; i++) applyStimulus(TXDATA_A, {24'h0, stream_bytes[i]});
        max_count = 0;
        for (int i = 4; i < 12; i++) begin
            pushed = 0;
            waited = 0;
            while (!pushed && waited < 20 * int'(sdiv) + 50) begin
                @(negedge clk);
                waited++;
                RWAddress = STATUS_A;
                MemRead = 1'b1;
                #1;
                rd = RdData;
                MemRead = 1'b0;
                if (int'(rd[7:4]) > max_count) max_count = int'(rd[7:4]);
                if (rd[0] == 1'b0 && rd[2] == 1'b0) begin
                    RWAddress = TXDATA_A;
                    WriteData = {24'h0, stream_bytes[i]};
                    MemWrite = 1'b1;
                    @(posedge clk);
                    #1 MemWrite = 1'b0;
                    pushed = 1;
                end
            end
            checkOutput($sformatf("stream_push_at_pop[%0d]", i), pushed, 1'b1);
        end
        checkOutput("stream_count_le_depth", max_count <= 4, 1'b1);
        wait_rx(12, 12 * 31 + 100);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(stream_bytes[i]);
        compare_rx();
        for (int i = 1; i < 12 && i < start_q.size(); i++)
            checkOutput($sformatf("stream_spacing[%0d]", i), start_q[i] - start_q[i-1], 10 * sdiv + 1);
        rx_q.delete();
        start_q.delete();

        // Divisor change mid-frame applies to the following frame only.
        applyStimulus(BAUDDIV_A, 32'd8);
        applyStimulus(TXDATA_A, 32'h0000_00C3);
        applyStimulus(TXDATA_A, 32'h0000_005A);
        repeat (30) @(negedge clk);
        applyStimulus(BAUDDIV_A, 32'd2);
        wait_rx(2, 81 + 21 + 50);
        exp_q = '{8'hC3, 8'h5A};
        compare_rx();
        if (start_q.size() >= 2) checkOutput("divchange_spacing", start_q[1] - start_q[0], 81);
        else checkOutput("divchange_starts", start_q.size(), 2);
        bus_read(BAUDDIV_A, rd, rd_sel);
        checkOutput("divchange_bauddiv", rd, 32'd2);
        rx_q.delete();
        start_q.delete();

        // Reset mid-frame aborts the byte.
        applyStimulus(BAUDDIV_A, 32'd8);
        applyStimulus(TXDATA_A, 32'h0000_003C);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("midframe_reset_tx", tx, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_div = 434;
        bus_read(STATUS_A, rd, rd_sel);
        checkOutput("midframe_reset_status", rd, 32'h4);
        bus_read(BAUDDIV_A, rd, rd_sel);
        checkOutput("midframe_reset_bauddiv", rd, 32'd434);
        repeat (100) @(negedge clk);
        checkOutput("midframe_reset_no_resume", rx_q.size(), 0);
        checkOutput("midframe_reset_idle_tx", tx, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the multicycle core's single memory bus, downstream of the core's MemRead/MemWrite/RWAddress/WriteData outputs.
- Decodes a 16-byte window at BASE_ADDR and buffers bytes written by `sw` in a small FIFO.
- Serializes the bytes 8N1 on `tx`.
- Supplies read data (status, baud divisor) that the system bus mux routes back to the core's MemData input.

Parameters:
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width.
- BASE_ADDR, 32'h1001_0000, window base; bits [3:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- BAUD_DIV_RST, 16'd434, reset value of the baud divisor (clk cycles per bit).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- MemWrite, input, 1, bus write strobe from the core.
- MemRead, input, 1, bus read strobe from the core.
- RWAddress, input, ADDR_WIDTH, bus byte address.
- WriteData, input, DATA_WIDTH, bus write data.
- Sel, output, 1, combinational: 1 when RWAddress[31:4]==BASE_ADDR[31:4].
- RdData, output, DATA_WIDTH, combinational read data.
- tx, output, 1, serial line; idles high.

Behaviour:
- Reset (rst=0, async): FIFO emptied, pointers and count 0, FSM IDLE, tx=1, BAUDDIV=BAUD_DIV_RST, OVF=0. Reset mid-frame aborts the frame: tx goes 1 immediately, no partial byte is resumed.
- Register map (offset = RWAddress[3:2]; RWAddress[1:0] ignored):
  - 0x0 TXDATA (W): push WriteData[7:0]. Reads return 0.
  - 0x4 STATUS (R): bit0 BUSY (FSM!=IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[7:4] FIFO count, upper bits 0. Writing with WriteData[3]=1 clears OVF; other written bits are ignored.
  - 0x8 BAUDDIV (R/W): bits[15:0]. A written 0 is stored as 1. Reads are zero-extended.
  - 0xC: reads 0, writes ignored.
- Reads: RdData = register value when Sel & MemRead, else 0. Read is zero-latency combinational, valid in the same cycle as the address. Reads have no side effects.
- Writes are committed on the rising edge where Sel & MemWrite.
- Push to TXDATA:
  - Accepted if FULL is 0 before the edge.
  - If FULL=1, the byte is dropped and OVF is set. This holds even if a pop occurs in the same cycle (full is evaluated pre-edge).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on an edge where EMPTY=0 (pre-edge), pop the head byte into the shift register, latch BAUDDIV into the bit-period register, clear the baud and bit counters, and go to START.
  - A push into an empty FIFO at edge N pops at edge N+1. tx falls after edge N+1.
  - START: tx=0 for BAUDDIV cycles, then DATA.
  - DATA: tx=shift[0], shifting right each bit period. After 8 bit periods, LSB first, go to STOP.
  - STOP: tx=1 for BAUDDIV cycles, then IDLE. At least 1 idle cycle separates frames.
- Baud counter counts 0..div-1 and advances the bit on the edge where the count equals div-1. A BAUDDIV write mid-frame affects the next frame only.
- Frame length = 10*div cycles, plus 1 IDLE cycle between back-to-back frames.
- Simultaneous push and pop in the same cycle (not full): count is unchanged; both the write pointer and read pointer advance modulo FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. FULL = count==FIFO_DEPTH. EMPTY = count==0.
- Accesses outside the window: Sel=0, RdData=0, no state change.

Test Plan:
- Reset check: hold rst=0 → tx=1; read STATUS at 0x1001_0004 returns 32'h0000_0004; read BAUDDIV at 0x1001_0008 returns 434.
- Single frame: write BAUDDIV=4, then write TXDATA=32'h0000_00A5.
  - tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
  - BUSY=1 throughout the frame; STATUS returns 0x04 afterwards.
- Overflow: BAUDDIV=4, write 6 bytes back-to-back (0x11..0x16).
  - The first byte pops, 4 are buffered, and byte 0x16 is dropped.
  - STATUS shows FULL=1, OVF=1, count=4.
  - Transmitted order is 0x11..0x15.
  - Writing STATUS with 0x8 clears OVF.
- Wrap-around plus simultaneous push/pop: stream 12 bytes, pushing each byte the cycle a pop occurs → all 12 transmitted in order; count never exceeds 4.
- Mid-frame divisor change and reset: BAUDDIV=8, start a frame, write BAUDDIV=2 during DATA → current frame keeps 8 cycles/bit and the next frame uses 2. Assert rst=0 mid-frame → tx=1 immediately and STATUS returns 0x04 after release.
- Decode: read 0x1001_0010 and 0x1000_0004 → Sel=0, RdData=0; writes to those addresses change nothing.
